interrupt_sequencer: RTL and testbench
======================================

// Module: interrupt_sequencer
// PURPOSE
//  Downstream of the interrupt latches: turns latched NMI_L/IRQ_L/RES_L into a 7-cycle
//  hardware-interrupt sequence for the control logic. It arbitrates priority at an
//  instruction boundary, forces BRK into the predecode path, and drives stack-write
//  suppression, vector address and load strobes, I-flag set and intHandled back to the PLA.
// PARAMETERS
//  VEC_NMI  16'hFFFA  NMI vector base (low byte address)
//  VEC_RES  16'hFFFC  reset vector base
//  VEC_IRQ  16'hFFFE  IRQ vector base
// PORTS
//  phi1         in   1   sequencing clock; all state changes on posedge phi1
//  rstAll       in   1   reset, asynchronous, active-high
//  nmiL         in   1   latched NMI_L, active-low, edge-sensitive
//  irqL         in   1   latched IRQ_L, active-low, level-sensitive
//  resL         in   1   latched RES_L, active-low, level-sensitive
//  iFlag        in   1   status register I bit; masks IRQ only
//  boundary     in   1   high during the last cycle of an instruction (T1 fetch next)
//  rdy          in   1   high = advance; low = freeze all state (outputs held)
//  activeInt    out  3   `NONE / `RST_i / `NMI_i / `IRQ_i for the interrupt in service
//  forceBrk     out  1   substitute opcode 8'h00 for the fetched byte
//  suppressWr   out  1   turn stack pushes into reads (reset sequence only)
//  vecAddr      out  16  vector byte address to drive during load cycles
//  vecLoadLo    out  1   load PCL from data bus
//  vecLoadHi    out  1   load PCH from data bus
//  setIFlag     out  1   set status I
//  bFlagOut     out  1   B bit value for the pushed P; always 0 from this block
//  intHandled   out  1   one-cycle pulse after the sequence completes
// BEHAVIOUR
//  Reset: state IDLE, cnt=0, nmiPend=0, nmiPrev=1, activeInt=`NONE. All strobes 0,
//   vecAddr=16'h0000.
//  NMI detect: nmiPrev<=nmiL every enabled cycle. nmiPend sets when nmiPrev=1 and nmiL=0.
//   nmiPend clears only when an NMI sequence reaches cnt=5. Level-held low makes no new edge.
//  IRQ request = ~irqL & ~iFlag, sampled at the boundary. No latching; release before the
//   boundary means it is not taken.
//  States: IDLE -> SEQ on boundary & request (RES > NMI > IRQ); activeInt set on entry.
//   Any state -> HOLD_RES while resL=0 (aborts a sequence and clears strobes). HOLD_RES ->
//   SEQ(`RST_i, cnt=0) on the first cycle with resL=1, without waiting for boundary.
//  SEQ, cnt 0..6, one step per cycle with rdy=1:
//   cnt0-1  forceBrk=1
//   cnt2-4  stack pushes PCH/PCL/P; suppressWr=1 iff `RST_i
//   cnt5    vecAddr=base, vecLoadLo=1
//   cnt6    vecAddr=base+1, vecLoadHi=1, setIFlag=1
//   next    IDLE, intHandled=1 for 1 cycle, activeInt=`NONE
//  Hijack: an NMI edge (or pending NMI) during an IRQ sequence at cnt<=4 switches
//   activeInt to `NMI_i; the sequence continues with the NMI vector. At cnt>=5 it waits.
//  Simultaneous: NMI edge and IRQ at the same boundary -> NMI taken; IRQ re-evaluated at
//   the next boundary. An edge arriving in the cnt=6 or intHandled cycle stays pending.
//  vecAddr+1 is 16-bit, with no wrap concern at the defaults.
//  rdy=0 freezes cnt/state/nmiPrev; nmiPend still sets. Reset entry ignores rdy.
// TESTING
//  1 rstAll pulse, resL 0 for 3 cycles then 1 -> SEQ `RST_i; suppressWr at cnt2-4;
//    vecAddr FFFC then FFFD; intHandled at cycle 7.
//  2 iFlag=0, irqL=0 at boundary -> forceBrk cnt0-1; vecLoadLo at FFFE, vecLoadHi at
//    FFFF; setIFlag at cnt6; bFlagOut=0.
//  3 iFlag=1, irqL=0 across 3 boundaries -> stays IDLE, activeInt=`NONE.
//  4 IRQ sequence with nmiL falling at cnt3 -> vecAddr FFFA/FFFB; nmiPend=0 after cnt5;
//    no second NMI while nmiL is held low.
//  5 resL=0 at cnt4 of an NMI -> strobes drop next cycle; HOLD_RES; after release, full
//    reset sequence.
//  6 rdy=0 for 2 cycles at cnt5 -> vecLoadLo held 3 cycles, total length 9 cycles.

Source files
------------

// File: rtl/interrupt_sequencer_if.sv
// Signal bundle between the interrupt latches/control logic and the interrupt sequencer.
// The sequencer is the slave: it samples the request/status inputs and drives the sequence strobes.
`ifndef INTERRUPT_SEQUENCER_KINDS
`define INTERRUPT_SEQUENCER_KINDS
`define NONE  3'd0
`define RST_i 3'd1
`define NMI_i 3'd2
`define IRQ_i 3'd3
`endif

interface interrupt_sequencer_if;
    logic        nmiL;
    logic        irqL;
    logic        resL;
    logic        iFlag;
    logic        boundary;
    logic        rdy;
    logic [2:0]  activeInt;
    logic        forceBrk;
    logic        suppressWr;
    logic [15:0] vecAddr;
    logic        vecLoadLo;
    logic        vecLoadHi;
    logic        setIFlag;
    logic        bFlagOut;
    logic        intHandled;

    modport master (
        output nmiL, irqL, resL, iFlag, boundary, rdy,
        input  activeInt, forceBrk, suppressWr, vecAddr, vecLoadLo, vecLoadHi,
               setIFlag, bFlagOut, intHandled
    );

    modport slave (
        input  nmiL, irqL, resL, iFlag, boundary, rdy,
        output activeInt, forceBrk, suppressWr, vecAddr, vecLoadLo, vecLoadHi,
               setIFlag, bFlagOut, intHandled
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// Turns latched NMI/IRQ/RES requests into the 7-step hardware interrupt sequence.
// All outputs are registered and computed from the next state, so they line up with the step they describe.
module interrupt_sequencer #(
    parameter logic [15:0] VEC_NMI = 16'hFFFA,
    parameter logic [15:0] VEC_RES = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ = 16'hFFFE
) (
    input  logic                  phi1,
    input  logic                  rstAll,
    interrupt_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEQ      = 2'd1,
        ST_HOLD_RES = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic [2:0]  active_r, active_s;
    logic        nmi_pend_r, nmi_pend_s;
    logic        nmi_prev_r, nmi_prev_s;
    logic        handled_r, handled_s;
    logic        nmi_edge_s, nmi_req_s, irq_req_s;

    logic        force_brk_r, force_brk_s;
    logic        suppress_wr_r, suppress_wr_s;
    logic [15:0] vec_addr_r, vec_addr_s;
    logic        vec_lo_r, vec_lo_s;
    logic        vec_hi_r, vec_hi_s;
    logic        set_i_r, set_i_s;

    function automatic logic [15:0] vec_base(input logic [2:0] kind);
        case (kind)
            `NMI_i:  vec_base = VEC_NMI;
            `RST_i:  vec_base = VEC_RES;
            `IRQ_i:  vec_base = VEC_IRQ;
            default: vec_base = 16'h0000;
        endcase
    endfunction

    // Next-state: reset hold overrides everything, otherwise advance only when rdy is high.
    always_comb begin
        nmi_edge_s = nmi_prev_r & ~bus.nmiL;
        nmi_req_s  = nmi_pend_r | nmi_edge_s;
        irq_req_s  = ~bus.irqL & ~bus.iFlag;
        state_s    = state_r;
        cnt_s      = cnt_r;
        active_s   = active_r;
        handled_s  = handled_r;
        nmi_prev_s = nmi_prev_r;
        nmi_pend_s = nmi_req_s;
        if (!bus.resL) begin
            state_s    = ST_HOLD_RES;
            cnt_s      = 3'd0;
            active_s   = `NONE;
            handled_s  = 1'b0;
            nmi_prev_s = bus.rdy ? bus.nmiL : nmi_prev_r;
        end else if (bus.rdy) begin
            nmi_prev_s = bus.nmiL;
            handled_s  = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.boundary && nmi_req_s) begin
                        state_s  = ST_SEQ;
                        cnt_s    = 3'd0;
                        active_s = `NMI_i;
                    end else if (bus.boundary && irq_req_s) begin
                        state_s  = ST_SEQ;
                        cnt_s    = 3'd0;
                        active_s = `IRQ_i;
                    end else begin
                        state_s  = ST_IDLE;
                    end
                end
                ST_SEQ: begin
                    if (cnt_r == 3'd6) begin
                        state_s   = ST_IDLE;
                        cnt_s     = 3'd0;
                        active_s  = `NONE;
                        handled_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + 3'd1;
                        // An NMI may still hijack an IRQ while the vector has not been fetched.
                        if (active_r == `IRQ_i && nmi_req_s && cnt_r <= 3'd4) begin
                            active_s = `NMI_i;
                        end else begin
                            active_s = active_r;
                        end
                        if (cnt_r == 3'd4 && active_s == `NMI_i) begin
                            nmi_pend_s = 1'b0;
                        end else begin
                            nmi_pend_s = nmi_req_s;
                        end
                    end
                end
                ST_HOLD_RES: begin
                    state_s  = ST_SEQ;
                    cnt_s    = 3'd0;
                    active_s = `RST_i;
                end
                default: begin
                    state_s  = ST_IDLE;
                    cnt_s    = 3'd0;
                    active_s = `NONE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Strobe decode from the upcoming step so the registered outputs match it.
    always_comb begin
        force_brk_s   = (state_s == ST_SEQ) && (cnt_s <= 3'd1);
        suppress_wr_s = (state_s == ST_SEQ) && (cnt_s >= 3'd2) && (cnt_s <= 3'd4) && (active_s == `RST_i);
        vec_lo_s      = (state_s == ST_SEQ) && (cnt_s == 3'd5);
        vec_hi_s      = (state_s == ST_SEQ) && (cnt_s == 3'd6);
        set_i_s       = vec_hi_s;
        if (vec_lo_s) begin
            vec_addr_s = vec_base(active_s);
        end else if (vec_hi_s) begin
            vec_addr_s = vec_base(active_s) + 16'd1;
        end else begin
            vec_addr_s = 16'h0000;
        end
    end

    // State and output registers.
    always_ff @(posedge phi1 or posedge rstAll) begin
        if (rstAll) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 3'd0;
            active_r      <= `NONE;
            nmi_pend_r    <= 1'b0;
            nmi_prev_r    <= 1'b1;
            handled_r     <= 1'b0;
            force_brk_r   <= 1'b0;
            suppress_wr_r <= 1'b0;
            vec_addr_r    <= 16'h0000;
            vec_lo_r      <= 1'b0;
            vec_hi_r      <= 1'b0;
            set_i_r       <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            active_r      <= active_s;
            nmi_pend_r    <= nmi_pend_s;
            nmi_prev_r    <= nmi_prev_s;
            handled_r     <= handled_s;
            force_brk_r   <= force_brk_s;
            suppress_wr_r <= suppress_wr_s;
            vec_addr_r    <= vec_addr_s;
            vec_lo_r      <= vec_lo_s;
            vec_hi_r      <= vec_hi_s;
            set_i_r       <= set_i_s;
        end
    end

    assign bus.activeInt  = active_r;
    assign bus.forceBrk   = force_brk_r;
    assign bus.suppressWr = suppress_wr_r;
    assign bus.vecAddr    = vec_addr_r;
    assign bus.vecLoadLo  = vec_lo_r;
    assign bus.vecLoadHi  = vec_hi_r;
    assign bus.setIFlag   = set_i_r;
    assign bus.bFlagOut   = 1'b0;
    assign bus.intHandled = handled_r;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Randomized episode bench for interrupt_sequencer: episodes push expected sequence records,
// a negedge monitor collects each observed sequence and compares it at intHandled.
module tb_interrupt_sequencer;
    localparam logic [2:0] K_NONE = 3'd0;
    localparam logic [2:0] K_RST  = 3'd1;
    localparam logic [2:0] K_NMI  = 3'd2;
    localparam logic [2:0] K_IRQ  = 3'd3;

    typedef struct {
        logic [2:0] kind;
        int         len;
        int         brk_n;
        int         lo_n;
        int         hi_n;
        int         supp_n;
    } exp_t;

    logic phi1 = 1'b0;
    logic rstAll;
    interrupt_sequencer_if bus ();

    interrupt_sequencer dut (
        .phi1   (phi1),
        .rstAll (rstAll),
        .bus    (bus)
    );

    always #5 phi1 = ~phi1;

    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];
    bit   model_pend = 1'b0;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int base_of(input logic [2:0] k);
        case (k)
            K_NMI:   return 32'hFFFA;
            K_RST:   return 32'hFFFC;
            K_IRQ:   return 32'hFFFE;
            default: return 32'h0;
        endcase
    endfunction

    task automatic push(input logic [2:0] k, input int len = 7, input int brk = 2,
                        input int lo = 1, input int hi = 1);
        exp_t e;
        e.kind = k; e.len = len; e.brk_n = brk; e.lo_n = lo; e.hi_n = hi;
        e.supp_n = (k == K_RST) ? 3 : 0;
        sbq.push_back(e);
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge phi1);
            #1;
        end
    endtask

    task automatic boundary_pulse();
        bus.boundary = 1'b1;
        cyc();
        bus.boundary = 1'b0;
    endtask

    // Monitor: gathers one sequence from its first forceBrk cycle up to intHandled.
    bit         coll = 1'b0, prev_brk = 1'b0;
    int         m_len, m_brk, m_lo, m_hi, m_supp, m_seti, m_bflag, m_lo_a, m_hi_a;
    logic [2:0] m_kind;
    initial begin
        exp_t e;
        forever begin
            @(negedge phi1);
            if (!rstAll) begin
                if (bus.forceBrk && !prev_brk) begin
                    coll = 1'b1; m_len = 0; m_brk = 0; m_lo = 0; m_hi = 0; m_supp = 0;
                    m_seti = 0; m_bflag = 0; m_lo_a = 0; m_hi_a = 0; m_kind = K_NONE;
                end
                if (bus.intHandled) begin
                    check("seq_expected", int'(sbq.size() > 0), 1);
                    check("handled_active_none", bus.activeInt, K_NONE);
                    if (sbq.size() > 0) begin
                        e = sbq.pop_front();
                        check("seq_collected", int'(coll), 1);
                        check("seq_kind", m_kind, e.kind);
                        check("vec_lo_addr", m_lo_a, base_of(e.kind));
                        check("vec_hi_addr", m_hi_a, base_of(e.kind) + 1);
                        check("seq_len", m_len, e.len);
                        check("brk_cycles", m_brk, e.brk_n);
                        check("lo_cycles", m_lo, e.lo_n);
                        check("hi_cycles", m_hi, e.hi_n);
                        check("seti_cycles", m_seti, e.hi_n);
                        check("supp_cycles", m_supp, e.supp_n);
                        check("bflag_zero", m_bflag, 0);
                    end
                    coll = 1'b0;
                end else if (coll) begin
                    m_len++;
                    if (bus.forceBrk)   m_brk++;
                    if (bus.suppressWr) m_supp++;
                    if (bus.setIFlag)   m_seti++;
                    if (bus.bFlagOut)   m_bflag++;
                    if (bus.vecLoadLo) begin m_lo++; m_lo_a = bus.vecAddr; end
                    if (bus.vecLoadHi) begin m_hi++; m_hi_a = bus.vecAddr; m_kind = bus.activeInt; end
                end
                prev_brk = bus.forceBrk;
            end
        end
    end

    // Closing probe: a pending NMI is taken at the next boundary; a level-held nmiL makes no new one.
    task automatic probe();
        bus.irqL = 1'b1;
        if (model_pend) push(K_NMI);
        boundary_pulse();
        model_pend = 1'b0;
        cyc(9);
        boundary_pulse();
        cyc(9);
        bus.nmiL = 1'b1;
        cyc(2);
    endtask

    task automatic ep_irq(input bit masked);
        bus.iFlag = masked;
        bus.irqL  = 1'b0;
        if (masked) begin
            repeat (3) begin
                boundary_pulse();
                cyc(2);
                check("masked_idle_active", bus.activeInt, K_NONE);
                check("masked_idle_brk", bus.forceBrk, 0);
            end
        end else begin
            push(K_IRQ);
            boundary_pulse();
            bus.irqL = 1'b1;
            cyc(9);
        end
        bus.irqL  = 1'b1;
        bus.iFlag = 1'b0;
    endtask

    task automatic ep_nmi(input bit with_irq);
        bus.nmiL = 1'b0;
        bus.irqL = with_irq ? 1'b0 : 1'b1;
        push(K_NMI);
        boundary_pulse();
        cyc(9);
        if (with_irq) begin
            push(K_IRQ);
            boundary_pulse();
            bus.irqL = 1'b1;
            cyc(9);
        end
        model_pend = 1'b0;
    endtask

    task automatic ep_hijack(input int k);
        bus.irqL = 1'b0;
        boundary_pulse();
        bus.irqL = 1'b1;
        cyc(k);
        bus.nmiL = 1'b0;
        if (k <= 4) begin
            push(K_NMI);
        end else begin
            push(K_IRQ);
            model_pend = 1'b1;
        end
        cyc(9 - k);
    endtask

    task automatic ep_abort(input bit nmi_start, input int j, input int h);
        if (nmi_start) bus.nmiL = 1'b0;
        else           bus.irqL = 1'b0;
        boundary_pulse();
        bus.irqL = 1'b1;
        cyc(j);
        bus.resL = 1'b0;
        cyc();
        check("abort_strobes_zero",
              int'({bus.forceBrk, bus.suppressWr, bus.vecLoadLo, bus.vecLoadHi,
                    bus.setIFlag, bus.intHandled}), 0);
        check("abort_vecaddr_zero", bus.vecAddr, 0);
        cyc(h - 1);
        bus.resL = 1'b1;
        push(K_RST);
        cyc(9);
        model_pend = nmi_start && (j <= 4);
    endtask

    task automatic ep_stall(input int m, input int s);
        bus.irqL = 1'b0;
        boundary_pulse();
        bus.irqL = 1'b1;
        cyc(m);
        bus.rdy = 1'b0;
        cyc(s);
        bus.rdy = 1'b1;
        push(K_IRQ, 7 + s, 2 + ((m <= 1) ? s : 0), 1 + ((m == 5) ? s : 0), 1 + ((m == 6) ? s : 0));
        cyc(9 - m);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int kind;
        rstAll = 1'b1;
        bus.nmiL = 1'b1; bus.irqL = 1'b1; bus.resL = 1'b0;
        bus.iFlag = 1'b0; bus.boundary = 1'b0; bus.rdy = 1'b1;
        cyc(2);
        check("rst_active", bus.activeInt, K_NONE);
        check("rst_strobes",
              int'({bus.forceBrk, bus.suppressWr, bus.vecLoadLo, bus.vecLoadHi,
                    bus.setIFlag, bus.bFlagOut, bus.intHandled}), 0);
        check("rst_vecaddr", bus.vecAddr, 0);
        rstAll = 1'b0;
        cyc(3);
        bus.resL = 1'b1;
        push(K_RST);
        cyc(10);

        ep_irq(1'b0);      probe();
        ep_irq(1'b1);      probe();
        ep_nmi(1'b1);      probe();
        ep_hijack(3);      probe();
        ep_hijack(6);      probe();
        ep_abort(1'b1, 4, 2); probe();
        ep_stall(5, 2);    probe();

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: ep_irq(1'($urandom_range(0, 1)));
                1: ep_nmi(1'($urandom_range(0, 1)));
                2: ep_hijack($urandom_range(0, 7));
                3: ep_abort(1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom_range(1, 4));
                default: ep_stall($urandom_range(0, 6), $urandom_range(1, 3));
            endcase
            probe();
        end

        for (int w = 0; w < 50 && sbq.size() > 0; w++) cyc();
        check("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
